// File: rtl/muldiv_unit_pkg.sv
// Shared widths, op codes and state encoding for the EX-stage multiply/divide unit.
package muldiv_unit_pkg;

  localparam int DATA_W  = 32;
  localparam int MD_OP_W = 2;

  localparam logic [MD_OP_W-1:0] MD_MULT  = 2'b00;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 2'b01;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 2'b10;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  // Magnitude of a two's-complement value; passes the value through when en is low.
  function automatic logic [DATA_W-1:0] md_abs(input logic [DATA_W-1:0] v, input logic en);
    return (en && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU beside the ALU; owns HI/LO.
// Multiply done 3 cycles after start, divide 34; start ignored while busy, cancel aborts.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [DATA_W-1:0]  in_0,
  input  logic [DATA_W-1:0]  in_1,
  input  logic               cancel,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [DATA_W-1:0]  wdata,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo
);

  md_state_e               state_q, state_d;
  logic [2*DATA_W-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0]       b_q, b_d;
  logic [DATA_W-1:0]       hi_q, hi_d;
  logic [DATA_W-1:0]       lo_q, lo_d;
  logic [4:0]              cnt_q, cnt_d;
  logic                    sign_a_q, sign_a_d;
  logic                    sign_b_q, sign_b_d;
  logic                    is_div_q, is_div_d;
  logic                    divzero_q, divzero_d;
  logic                    done_q, done_d;

  logic                    sgn_in;
  logic [DATA_W:0]         rem_sh;
  logic [DATA_W:0]         rem_diff;
  logic                    rem_ge;
  logic [2*DATA_W-1:0]     prod_fix;
  logic [DATA_W-1:0]       quo_fix;
  logic [DATA_W-1:0]       rem_fix;

  // acc holds the product for multiplies, and {remainder, dividend/quotient} for divides.
  assign sgn_in   = ~op[0];
  assign rem_sh   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
  assign rem_diff = rem_sh - {1'b0, b_q};
  assign rem_ge   = ~rem_diff[DATA_W];

  assign prod_fix = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
  assign rem_fix  = sign_a_q ? (~acc_q[2*DATA_W-1:DATA_W] + 1'b1) : acc_q[2*DATA_W-1:DATA_W];
  always_comb begin
    quo_fix = (sign_a_q ^ sign_b_q) ? (~acc_q[DATA_W-1:0] + 1'b1) : acc_q[DATA_W-1:0];
    if (divzero_q) quo_fix = '1;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    is_div_d  = is_div_q;
    divzero_d = divzero_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !cancel) begin
          sign_a_d  = sgn_in & in_0[DATA_W-1];
          sign_b_d  = sgn_in & in_1[DATA_W-1];
          is_div_d  = op[1];
          divzero_d = (in_1 == '0);
          acc_d     = {{DATA_W{1'b0}}, md_abs(in_0, sgn_in)};
          b_d       = md_abs(in_1, sgn_in);
          cnt_d     = '0;
          state_d   = op[1] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        acc_d   = (2*DATA_W)'(acc_q[DATA_W-1:0]) * (2*DATA_W)'(b_q);
        state_d = ST_FIX;
      end
      ST_DIV: begin
        // One restoring step; the 33-bit compare keeps large divisors exact.
        acc_d[2*DATA_W-1:DATA_W] = rem_ge ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
        acc_d[DATA_W-1:0]        = {acc_q[DATA_W-2:0], rem_ge};
        cnt_d                    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*DATA_W-1:DATA_W];
          lo_d = prod_fix[DATA_W-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (cancel && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      is_div_q  <= 1'b0;
      divzero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      is_div_q  <= is_div_d;
      divzero_q <= divzero_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, directly beside the single-cycle ALU.
- Consumes the same rs/rt operands the ALU receives.
- Executes MULT/MULTU/DIV/DIVU and owns the architectural HI/LO registers.
- Drives busy to the hazard/stall logic; HI/LO feed the EX result mux for MFHI/MFLO.

Parameters:
- none: data width is `DATA_W (32) from the shared defines; the op field width comes from the shared defines.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  2  MD_MULT=00, MD_MULTU=01, MD_DIV=10, MD_DIVU=11.
- in_0  in  32  rs (multiplicand / dividend).
- in_1  in  32  rt (multiplier / divisor).
- cancel  in  1  pipeline flush; aborts any operation in flight.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  32  MTHI/MTLO data.
- busy  out  1  operation in flight (state != IDLE).
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, internal regs=0. Reset mid-operation discards the operation with no HI/LO write.
- States:
  - IDLE: start=1 and cancel=0 latches |in_0|, |in_1| (absolute values for signed ops only), sign_a, sign_b, op, and divzero=(in_1==0). Next state is MUL for MULT/MULTU, DIV for DIV/DIVU.
  - MUL: one cycle; registers the 64-bit unsigned product of the latched magnitudes; next FIX.
  - DIV: 32 restoring iterations, counter 0..31. Each iteration: rem={rem[30:0],dividend msb}, shift dividend; if rem>=divisor then rem-=divisor and quotient bit=1. After count 31 -> FIX.
  - FIX: apply signs. Signed MULT: negate the 64-bit product if sign_a^sign_b. Signed DIV: negate quotient if sign_a^sign_b; remainder takes sign_a. Write hi/lo at the edge leaving FIX; next IDLE; done=1 for exactly the following cycle.
- Results: MULT/MULTU gives hi=product[63:32], lo=product[31:0]. DIV/DIVU gives lo=quotient, hi=remainder.
- Latency (start high in cycle 0):
  - Multiply: busy cycles 1-2, done and valid HI/LO in cycle 3.
  - Divide: busy cycles 1-33, done in cycle 34.
  - A back-to-back start is accepted in the done cycle.
- Divide by zero: no exception and same latency; lo=32'hFFFFFFFF, hi=original in_0 (unsigned and signed alike).
- DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0, no flag.
- Arithmetic is modulo 2^32 per half; no overflow output.
- start while busy: ignored.
- cancel: any non-IDLE state returns to IDLE at the next edge with no done and no HI/LO write. cancel with start in IDLE: cancel wins, nothing launched.
- hi_we/lo_we: take effect at the edge only when state==IDLE; ignored while busy. hi_we with start in the same IDLE cycle: HI is written and the operation is also launched; the result later overwrites HI/LO.
- done and busy are never high together.

Decomposition:
- Shared defines: MD op codes and the op bus width `MdOpBus, alongside the existing `DataBus/`DATA_W and `ENABLED/`DISABLED.
- Use local parameters for state encoding (IDLE/MUL/DIV/FIX).
- No sub-module is natural; sign handling and the division step stay inline.

Test Plan:
- MULT in_0=32'hFFFFFFFD (-3), in_1=5 -> done in cycle 3, hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; busy high cycles 1-2 only.
- MULTU in_0=in_1=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
- DIV -7/2 -> done in cycle 34, lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIVU 100/7 -> lo=14, hi=2.
- DIV 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- DIVU 1234/0 -> lo=32'hFFFFFFFF, hi=1234.
- DIV started, cancel in cycle 10 -> busy low in cycle 11, no done, HI/LO unchanged; new MULT accepted in cycle 11.
- Direct writes: lo_we with wdata=32'hA5A5A5A5 in IDLE -> lo=32'hA5A5A5A5 next cycle; the same write while busy is ignored.
- Reset: rst_n low mid-divide -> hi/lo/busy/done all 0 immediately.
